robot_motion_ctrl: RTL
======================

# robot_motion_ctrl

Motion-sequencing controller for the robot. It consumes the 16-bit distance sample `dist_v` with a valid strobe and drives left/right motor speed and direction commands. It runs a cruise / slow / brake / turn state machine with timed phases, a sensor watchdog and a bounded-retry fault state. It sits between the distance-sensor front end and the motor drivers, inside `robot`.

## Interface
Parameters:
- `SPEED_W`, 8: motor speed command width
- `SAFE_DIST`, 16'd1000: at or above this, cruise speed is allowed
- `STOP_DIST`, 16'd300: below this, brake
- `CRUISE_SPEED`, 8'd200: speed in CRUISE
- `SLOW_SPEED`, 8'd80: speed in SLOW
- `TURN_SPEED`, 8'd120: speed in TURN
- `BRAKE_CYCLES`, 8: BRAKE duration in cycles (≥1)
- `TURN_CYCLES`, 32: length of one TURN attempt in cycles (≥1)
- `MAX_TURNS`, 4: number of consecutive TURN attempts before FAULT
- `TIMEOUT`, 256: cycles without `dist_valid` before FAULT

Ports:
- `clk`  in  1  system clock, rising edge
- `rstn`  in  1  asynchronous active-low reset
- `en`  in  1  run enable, level
- `dist_valid`  in  1  `dist_v` holds a new sample this cycle
- `dist_v`  in  16  distance sample, unsigned
- `mot_l`  out  SPEED_W  left motor speed
- `mot_r`  out  SPEED_W  right motor speed
- `dir_l`  out  1  left direction (1 = forward)
- `dir_r`  out  1  right direction (1 = forward)
- `state`  out  3  current state code
- `alarm`  out  1  high while in FAULT

## Operation
- State codes: IDLE=0, CRUISE=1, SLOW=2, BRAKE=3, TURN=4, FAULT=5.
- All comparisons are unsigned 16-bit. A sample is "far" if it is ≥ SAFE_DIST, "near" if it is < STOP_DIST, and "mid" otherwise.
- `dist_q` latches `dist_v` on every `dist_valid`. Its reset value is 16'h0000.
- `en`=0 forces IDLE on the next edge from any state, including FAULT. This has the highest priority. FAULT is left only through `en`=0 or reset.
- IDLE: `en`=1 → CRUISE. Clears the turn counter and the watchdog.
- CRUISE: a valid near sample → BRAKE; a valid mid sample → SLOW; otherwise stay.
- SLOW: a valid near sample → BRAKE; a valid far sample → CRUISE; otherwise stay.
- BRAKE: stays exactly BRAKE_CYCLES cycles, ignoring samples, then → TURN. On entry it loads the phase counter and clears the turn counter.
- TURN: stays TURN_CYCLES cycles. At expiry:
  - if `dist_q` is far → CRUISE and the turn counter clears;
  - else the turn counter is incremented; if the counter reaches MAX_TURNS → FAULT, otherwise TURN restarts with the counter reloaded.
  - Samples arriving during TURN update `dist_q` only.
- Watchdog: counts cycles since the last `dist_valid` in CRUISE, SLOW and TURN, and is held at 0 elsewhere. When the count reaches TIMEOUT → FAULT, with priority over the distance transitions (but not over `en`=0).
- FAULT: stays until `en`=0.
- Output decode, by state:
  - IDLE, BRAKE and FAULT: both speeds 0, both directions forward.
  - CRUISE: both `CRUISE_SPEED`, forward.
  - SLOW: both `SLOW_SPEED`, forward.
  - TURN: `mot_l`=`mot_r`=`TURN_SPEED`, `dir_l`=1, `dir_r`=0 (spin right).
  - `alarm` = (state == FAULT).

## Timing
- Reset values: state=IDLE, `mot_l`=`mot_r`=0, `dir_l`=`dir_r`=1, `alarm`=0, all counters 0.
- Reset asserts asynchronously at any time, including mid-BRAKE or mid-TURN. Deassertion is sampled on the next rising edge.
- All outputs are registered and update on the same edge as `state`. No output depends combinationally on any input.
- Latency from input to output is 1 cycle. A decision sampled at edge N shows on the outputs after edge N.
- BRAKE occupies exactly BRAKE_CYCLES consecutive cycles; TURN occupies TURN_CYCLES cycles per attempt.
- A `dist_valid` in the same cycle as a TURN expiry is latched first, and the expiry decision uses the new `dist_q`.
- `dist_valid` in the cycle where the watchdog would reach TIMEOUT resets the watchdog; no FAULT occurs.

## Test plan
- Reset, then `en`=1 with `dist_v`=16'h7FFF valid every cycle → state=1 one edge later, `mot_l`=`mot_r`=200 forward, `alarm`=0.
- From CRUISE, one valid 500 → SLOW, speeds 80. Then valid 1000 → CRUISE, speeds 200.
- From CRUISE, valid 200 → BRAKE for exactly 8 cycles with speeds 0, then TURN (`dir_r`=0, speeds 120). Valid 16'h7FFF during TURN → CRUISE at cycle 32 of TURN.
- Near samples held throughout → 4 TURN attempts of 32 cycles each → FAULT, `alarm`=1, speeds 0. Then `en`=0 → IDLE next edge, `alarm`=0.
- In CRUISE, stop `dist_valid` → FAULT after 256 cycles. Repeat with a valid pulse on cycle 256 → no FAULT.
- Assert `rstn`=0 mid-BRAKE and `en`=0 mid-TURN → all outputs at reset or IDLE values immediately and on the next edge, respectively.

Source files
------------

// File: rtl/robot_motion_ctrl.sv
// Motion sequencer: cruise/slow/brake/turn FSM with timed phases,
// sensor watchdog and bounded turn retries ending in FAULT.
//
// Ports:
//   clk, rstn          - clock, async active-low reset
//   en                 - run enable (0 forces IDLE)
//   dist_valid, dist_v - distance sample strobe and value
//   mot_l, mot_r       - registered motor speed commands
//   dir_l, dir_r       - registered directions (1 = forward)
//   state              - current state code
//   alarm              - high while in FAULT
module robot_motion_ctrl #(
    parameter int                 SPEED_W      = 8,
    parameter logic [15:0]        SAFE_DIST    = 16'd1000,
    parameter logic [15:0]        STOP_DIST    = 16'd300,
    parameter logic [SPEED_W-1:0] CRUISE_SPEED = 8'd200,
    parameter logic [SPEED_W-1:0] SLOW_SPEED   = 8'd80,
    parameter logic [SPEED_W-1:0] TURN_SPEED   = 8'd120,
    parameter int                 BRAKE_CYCLES = 8,
    parameter int                 TURN_CYCLES  = 32,
    parameter int                 MAX_TURNS    = 4,
    parameter int                 TIMEOUT      = 256
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               en,
    input  logic               dist_valid,
    input  logic [15:0]        dist_v,
    output logic [SPEED_W-1:0] mot_l,
    output logic [SPEED_W-1:0] mot_r,
    output logic               dir_l,
    output logic               dir_r,
    output logic [2:0]         state,
    output logic               alarm
);

    localparam int PH_W = 16;
    localparam int TC_W = $clog2(MAX_TURNS + 1);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CRUISE = 3'd1,
        S_SLOW   = 3'd2,
        S_BRAKE  = 3'd3,
        S_TURN   = 3'd4,
        S_FAULT  = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic [TC_W-1:0]    turn_q, turn_d;
    logic [WD_W-1:0]    wdog_q, wdog_d;
    logic [15:0]        dist_q, dist_d;
    logic [SPEED_W-1:0] mot_l_q, mot_l_d;
    logic [SPEED_W-1:0] mot_r_q, mot_r_d;
    logic               dir_l_q, dir_l_d;
    logic               dir_r_q, dir_r_d;
    logic               alarm_q, alarm_d;

    logic far_v, near_v, active, wd_fire, next_act;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        turn_d  = turn_q;
        wdog_d  = wdog_q;
        // A sample coincident with TURN expiry must steer that decision.
        dist_d  = dist_valid ? dist_v : dist_q;
        far_v   = dist_v >= SAFE_DIST;
        near_v  = dist_v < STOP_DIST;
        active  = (state_q == S_CRUISE) || (state_q == S_SLOW) ||
                  (state_q == S_TURN);
        wd_fire = active && !dist_valid &&
                  (wdog_q == WD_W'(TIMEOUT - 1));
        if (active) begin
            wdog_d = dist_valid ? '0 : wdog_q + 1'b1;
        end

        if (!en) begin
            state_d = S_IDLE;
        end else if (wd_fire) begin
            state_d = S_FAULT;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_CRUISE;
                    turn_d  = '0;
                end
                S_CRUISE, S_SLOW: begin
                    if (dist_valid && near_v) begin
                        state_d = S_BRAKE;
                        phase_d = PH_W'(BRAKE_CYCLES - 1);
                        turn_d  = '0;
                    end else if (dist_valid && far_v) begin
                        state_d = S_CRUISE;
                    end else if (dist_valid) begin
                        state_d = S_SLOW;
                    end
                end
                S_BRAKE: begin
                    if (phase_q == '0) begin
                        state_d = S_TURN;
                        phase_d = PH_W'(TURN_CYCLES - 1);
                    end else begin
                        phase_d = phase_q - 1'b1;
                    end
                end
                S_TURN: begin
                    if (phase_q != '0) begin
                        phase_d = phase_q - 1'b1;
                    end else if (dist_d >= SAFE_DIST) begin
                        state_d = S_CRUISE;
                        turn_d  = '0;
                    end else begin
                        turn_d = turn_q + 1'b1;
                        if (turn_q + 1'b1 == TC_W'(MAX_TURNS)) begin
                            state_d = S_FAULT;
                        end else begin
                            phase_d = PH_W'(TURN_CYCLES - 1);
                        end
                    end
                end
                S_FAULT: state_d = S_FAULT;
                default: state_d = S_IDLE;
            endcase
        end

        // Watchdog only runs in the sample-driven states.
        next_act = (state_d == S_CRUISE) || (state_d == S_SLOW) ||
                   (state_d == S_TURN);
        if (!next_act || !active) begin
            wdog_d = '0;
        end

        // Outputs are decoded from the next state so they change
        // on the same edge as state.
        mot_l_d = '0;
        mot_r_d = '0;
        dir_l_d = 1'b1;
        dir_r_d = 1'b1;
        alarm_d = 1'b0;
        unique case (state_d)
            S_CRUISE: begin
                mot_l_d = CRUISE_SPEED;
                mot_r_d = CRUISE_SPEED;
            end
            S_SLOW: begin
                mot_l_d = SLOW_SPEED;
                mot_r_d = SLOW_SPEED;
            end
            S_TURN: begin
                mot_l_d = TURN_SPEED;
                mot_r_d = TURN_SPEED;
                dir_r_d = 1'b0;
            end
            S_FAULT: alarm_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            turn_q  <= '0;
            wdog_q  <= '0;
            dist_q  <= '0;
            mot_l_q <= '0;
            mot_r_q <= '0;
            dir_l_q <= 1'b1;
            dir_r_q <= 1'b1;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            turn_q  <= turn_d;
            wdog_q  <= wdog_d;
            dist_q  <= dist_d;
            mot_l_q <= mot_l_d;
            mot_r_q <= mot_r_d;
            dir_l_q <= dir_l_d;
            dir_r_q <= dir_r_d;
            alarm_q <= alarm_d;
        end
    end

    assign state = state_q;
    assign mot_l = mot_l_q;
    assign mot_r = mot_r_q;
    assign dir_l = dir_l_q;
    assign dir_r = dir_r_q;
    assign alarm = alarm_q;

endmodule
